magic_square_seq: RTL

- Sequential, parametrised N x N magic-square checker; successor to the combinational 3x3 checker.
- Cells stream in row-major order over a valid/ready handshake. Row, column and diagonal sums are accumulated, lines are compared against the row-0 sum, and the row-0 sum is converted to BCD for the display digits.
- Sits between the cell-entry front end and the seven-segment display driver.

---
 rtl/magic_pkg.sv | 18 +
 rtl/bcd_convert_seq.sv | 45 ++++
 rtl/magic_square_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/magic_pkg.sv
// Shared types and elaboration-time sizing helpers for the sequential magic-square checker.
package magic_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, CONVERT, DONE} state_t;

  // Width that holds the largest possible line sum, n cells of all-ones.
  function automatic int sum_w(input int n, input int dw);
    return $clog2(n * ((1 << dw) - 1) + 1);
  endfunction

  function automatic bit bcd_ok(input int n, input int dw, input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p > longint'(n * ((1 << dw) - 1));
  endfunction

endpackage

// File: rtl/bcd_convert_seq.sv
// Sequential double-dabble: start loads the binary value, bcd is final SUM_W cycles later.
// done is high during the last shift cycle; bcd then holds until the next start.
module bcd_convert_seq #(
  parameter int SUM_W      = 6,
  parameter int BCD_DIGITS = 2
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic                    start,
  input  logic [SUM_W-1:0]        bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CW = $clog2(SUM_W + 1);

  logic [SUM_W-1:0]        sh;
  logic [CW-1:0]           cnt;
  logic [4*BCD_DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sh  <= '0;
      cnt <= '0;
      bcd <= '0;
    end else if (start) begin
      sh  <= bin;
      cnt <= CW'(SUM_W);
      bcd <= '0;
    end else if (cnt != '0) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt       <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/magic_square_seq.sv
// N x N magic-square checker: cells stream in row-major, lines are compared against row 0,
// and the row-0 sum is reported in binary and BCD once the grid has been checked.
module magic_square_seq
  import magic_pkg::*;
#(
  parameter int N                = 3,
  parameter int DIGIT_W          = 4,
  parameter int BCD_DIGITS       = 2,
  parameter int REQUIRE_DISTINCT = 1,
  localparam int SUM_W           = sum_w(N, DIGIT_W)
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic                    start,
  input  logic                    cell_valid,
  input  logic [DIGIT_W-1:0]      cell_data,
  output logic                    cell_ready,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    it_is_magic,
  output logic [SUM_W-1:0]        sum_bin,
  output logic [4*BCD_DIGITS-1:0] sum_bcd
);

  localparam int IDX_W = $clog2(N);
  localparam int KW    = $clog2(N + 2);

  if (N < 3) begin : g_chk_n
    $error("magic_square_seq: N must be at least 3");
  end
  if (!bcd_ok(N, DIGIT_W, BCD_DIGITS)) begin : g_chk_bcd
    $error("magic_square_seq: BCD_DIGITS too small for the largest line sum");
  end
  if (REQUIRE_DISTINCT != 0 && N * N > (1 << DIGIT_W) - 1) begin : g_chk_dist
    $error("magic_square_seq: DIGIT_W too narrow to hold 1..N*N");
  end

  state_t state, state_nxt;

  logic [IDX_W-1:0]        r, c;
  logic [KW-1:0]           k;
  logic [SUM_W-1:0]        row_acc, ref_sum, diag, anti;
  logic [SUM_W-1:0]        col [N];
  logic [2**DIGIT_W-1:0]   seen;
  logic                    bad;

  logic                    accept, last_cell, cell_bad, conv_start, conv_done;
  logic [SUM_W-1:0]        cell_ext, row_sum, chk_val;
  logic [4*BCD_DIGITS-1:0] conv_bcd;

  assign accept     = cell_valid && cell_ready;
  assign cell_ext   = SUM_W'(cell_data);
  assign row_sum    = row_acc + cell_ext;
  assign last_cell  = (r == IDX_W'(N - 1)) && (c == IDX_W'(N - 1));
  assign conv_start = (state == CHECK) && (k == KW'(N + 1));

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && last_cell) state_nxt = CHECK;
      CHECK:   if (k == KW'(N + 1)) state_nxt = CONVERT;
      CONVERT: if (conv_done) state_nxt = DONE;
      DONE:    if (result_valid && result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cell_ready = (state == LOAD);
    busy       = (state != IDLE);
  end

  // Zero, out of range, or a repeat of an earlier value all disqualify the grid.
  always_comb begin
    cell_bad = 1'b0;
    if (REQUIRE_DISTINCT != 0)
      cell_bad = (cell_data == '0) || (int'(cell_data) > N * N) || seen[cell_data];
  end

  // CHECK walks columns 0..N-1, then the main diagonal, then the anti-diagonal.
  always_comb begin
    chk_val = anti;
    if (k == KW'(N)) chk_val = diag;
    for (int i = 0; i < N; i++) begin
      if (k == KW'(i)) chk_val = col[i];
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r       <= '0;
      c       <= '0;
      k       <= '0;
      row_acc <= '0;
      ref_sum <= '0;
      diag    <= '0;
      anti    <= '0;
      seen    <= '0;
      bad     <= 1'b0;
      for (int i = 0; i < N; i++) col[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            r       <= '0;
            c       <= '0;
            k       <= '0;
            row_acc <= '0;
            diag    <= '0;
            anti    <= '0;
            seen    <= '0;
            bad     <= 1'b0;
            for (int i = 0; i < N; i++) col[i] <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            for (int i = 0; i < N; i++) begin
              if (c == IDX_W'(i)) col[i] <= col[i] + cell_ext;
            end
            if (r == c) diag <= diag + cell_ext;
            if (int'(r) + int'(c) == N - 1) anti <= anti + cell_ext;
            if (REQUIRE_DISTINCT != 0) seen[cell_data] <= 1'b1;
            if (cell_bad) bad <= 1'b1;
            if (c == IDX_W'(N - 1)) begin
              row_acc <= '0;
              c       <= '0;
              r       <= r + 1'b1;
              if (r == '0)                 ref_sum <= row_sum;
              else if (row_sum != ref_sum) bad     <= 1'b1;
            end else begin
              row_acc <= row_sum;
              c       <= c + 1'b1;
            end
          end
        end
        CHECK: begin
          if (chk_val != ref_sum) bad <= 1'b1;
          k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  bcd_convert_seq #(
    .SUM_W      (SUM_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bcd (
    .clock   (clock),
    .reset_L (reset_L),
    .start   (conv_start),
    .bin     (ref_sum),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Results are captured on the first DONE cycle and survive the return to IDLE.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      result_valid <= 1'b0;
      it_is_magic  <= 1'b0;
      sum_bin      <= '0;
      sum_bcd      <= '0;
    end else if (state == DONE) begin
      if (!result_valid) begin
        result_valid <= 1'b1;
        it_is_magic  <= !bad;
        sum_bin      <= ref_sum;
        sum_bcd      <= conv_bcd;
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule
